// File: rtl/stall_flush_unit.sv
// Hazard control for the 5-stage RV32I pipeline: load-use stall, taken-branch flush,
// data-memory wait freeze with a timeout watchdog, and saturating stall/flush counters.
module stall_flush_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       raddr1D,
    input  logic [4:0]       raddr2D,
    input  logic [4:0]       waddrE,
    input  logic             reg_wrE,
    input  logic [1:0]       wb_selE,
    input  logic             br_takenE,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           r_state;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_mem_hold;
    logic w_lw_use;

    // The first unacked cycle holds straight from the inputs; the ack cycle never holds.
    assign w_mem_hold = ((r_state == S_IDLE) && dmem_req && !dmem_ack) ||
                        ((r_state == S_WAIT) && !dmem_ack) ||
                        (r_state == S_ERR);

    assign w_lw_use = (wb_selE == 2'b10) && reg_wrE && (waddrE != 5'd0) &&
                      ((waddrE == raddr1D) || (waddrE == raddr2D));

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (rst) begin
            if (w_mem_hold) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (br_takenE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (w_lw_use) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 8'd0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dmem_req && !dmem_ack) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= 8'd0;
                    end
                end
                S_WAIT: begin
                    // A dropped request is treated as an abandoned access, not an error.
                    if (dmem_ack || !dmem_req) begin
                        r_state <= S_IDLE;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state   <= S_ERR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_ERR: begin
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (stallF && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flushD && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_stall_flush_unit.sv
// Directed-vector bench for stall_flush_unit with TIMEOUT=4 and CNT_W=2.
// Control outputs are packed as {stallF,stallD,stallE,stallM,flushD,flushE,flushW}.
module tb_stall_flush_unit;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 2;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LW   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_HOLD = 7'b1111001;

    logic             clk;
    logic             rst;
    logic [4:0]       raddr1D, raddr2D, waddrE;
    logic             reg_wrE;
    logic [1:0]       wb_selE;
    logic             br_takenE;
    logic             dmem_req, dmem_ack;
    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushW;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0]       ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    stall_flush_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .raddr1D   (raddr1D),
        .raddr2D   (raddr2D),
        .waddrE    (waddrE),
        .reg_wrE   (reg_wrE),
        .wb_selE   (wb_selE),
        .br_takenE (br_takenE),
        .dmem_req  (dmem_req),
        .dmem_ack  (dmem_ack),
        .stallF    (stallF),
        .stallD    (stallD),
        .stallE    (stallE),
        .stallM    (stallM),
        .flushD    (flushD),
        .flushE    (flushE),
        .flushW    (flushW),
        .mem_err   (mem_err),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    assign ctrl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic idle_inputs();
        raddr1D   = 5'd0;
        raddr2D   = 5'd0;
        waddrE    = 5'd0;
        reg_wrE   = 1'b0;
        wb_selE   = 2'b00;
        br_takenE = 1'b0;
        dmem_req  = 1'b0;
        dmem_ack  = 1'b0;
    endtask

    task automatic set_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [1:0] sel);
        waddrE  = rd;
        raddr1D = rs1;
        raddr2D = rs2;
        reg_wrE = 1'b1;
        wb_selE = sel;
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the falling edge.
    task automatic cyc(input string tag, input logic [6:0] exp);
        @(negedge clk);
        check_eq(tag, {25'd0, ctrl}, {25'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // Reset with a live load-use on the inputs: outputs must stay quiet.
        rst = 1'b0;
        idle_inputs();
        set_lw(5'd5, 5'd5, 5'd0, 2'b10);
        cyc("rst_ctrl_low", C_NONE);
        rst = 1'b1;
        idle_inputs();
        check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check_eq("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        check_eq("rst_mem_err", 32'(mem_err), 32'd0);

        // Load-use on rs1: exactly one bubble.
        set_lw(5'd5, 5'd5, 5'd0, 2'b10);
        cyc("lw_rs1", C_LW);
        idle_inputs();
        check_eq("lw_stall_cnt", 32'(stall_cnt), 32'd1);
        cyc("lw_released", C_NONE);

        // Load-use on rs2.
        set_lw(5'd9, 5'd3, 5'd9, 2'b10);
        cyc("lw_rs2", C_LW);

        // x0 destination and non-load select never stall.
        set_lw(5'd0, 5'd3, 5'd0, 2'b10);
        cyc("lw_x0", C_NONE);
        set_lw(5'd5, 5'd5, 5'd0, 2'b01);
        cyc("alu_no_stall", C_NONE);
        set_lw(5'd5, 5'd6, 5'd7, 2'b10);
        cyc("lw_no_match", C_NONE);
        idle_inputs();
        check_eq("stall_cnt_after_misc", 32'(stall_cnt), 32'd2);

        // Branch beats load-use.
        do_reset();
        set_lw(5'd5, 5'd5, 5'd0, 2'b10);
        br_takenE = 1'b1;
        cyc("br_over_lw", C_BR);
        idle_inputs();
        check_eq("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check_eq("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // Memory wait: three unacked cycles, branch pending during the wait.
        do_reset();
        dmem_req = 1'b1;
        cyc("mw_c1", C_HOLD);
        br_takenE = 1'b1;
        cyc("mw_c2_br", C_HOLD);
        cyc("mw_c3_br", C_HOLD);
        dmem_ack = 1'b1;
        cyc("mw_ack_br", C_BR);
        idle_inputs();
        check_eq("mw_stall_cnt", 32'(stall_cnt), 32'd3);
        check_eq("mw_flush_cnt", 32'(flush_cnt), 32'd1);
        check_eq("mw_no_err", 32'(mem_err), 32'd0);
        cyc("mw_back_idle", C_NONE);

        // Abandoned access: request drops while waiting, FSM returns to idle.
        dmem_req = 1'b1;
        cyc("ab_c1", C_HOLD);
        dmem_req = 1'b0;
        @(posedge clk);
        #1;
        cyc("ab_idle", C_NONE);
        check_eq("ab_no_err", 32'(mem_err), 32'd0);

        // Timeout: one idle cycle plus four unacked wait cycles, then error.
        do_reset();
        dmem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("to_hold_%0d", i), C_HOLD);
            check_eq($sformatf("to_err_%0d", i), 32'(mem_err), (i == 4) ? 32'd1 : 32'd0);
        end
        dmem_req = 1'b0;
        br_takenE = 1'b1;
        cyc("err_frozen", C_HOLD);
        check_eq("err_sticky", 32'(mem_err), 32'd1);
        check_eq("err_stall_sat", 32'(stall_cnt), 32'd3);
        rst = 1'b0;
        cyc("err_rst_low", C_NONE);
        rst = 1'b1;
        check_eq("err_cleared", 32'(mem_err), 32'd0);
        check_eq("err_cnt_cleared", 32'(stall_cnt), 32'd0);
        cyc("err_released_br", C_BR);
        br_takenE = 1'b0;

        // Counter saturation at 2'b11.
        do_reset();
        set_lw(5'd7, 5'd7, 5'd7, 2'b10);
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("sat_lw_%0d", i), C_LW);
            check_eq($sformatf("sat_cnt_%0d", i), 32'(stall_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        idle_inputs();
        cyc("sat_idle", C_NONE);
        check_eq("sat_hold", 32'(stall_cnt), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stall_flush_unit.md
# stall_flush_unit

Pipeline control block for the 5-stage RV32I core; the counterpart of the forwarding unit. The forwarding unit steers results already in M/W into EXE. This block handles the cases forwarding cannot cover. It stalls IF/ID on a load-use dependency, flushes ID/EXE on a taken branch or jump, and freezes the whole pipeline while a data-memory access waits for its acknowledge. It also keeps a memory-timeout watchdog and stall/flush event counters.

## Interface
- `TIMEOUT`, default 16: cycles a data-memory request may wait for `dmem_ack` before the error state; legal range 2..255.
- `CNT_W`, default 16: width of the event counters.

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, synchronous, active-low.
- `raddr1D`, `raddr2D` input 5: rs1/rs2 of the instruction in ID.
- `waddrE` input 5: rd of the instruction in EXE.
- `reg_wrE` input 1: EXE instruction writes the register file.
- `wb_selE` input 2: EXE write-back select; `2'b10` means load data.
- `br_takenE` input 1: branch/jump resolved taken in EXE.
- `dmem_req` input 1: M stage holds a valid load/store.
- `dmem_ack` input 1: data memory completes the M-stage access this cycle.
- `stallF`, `stallD`, `stallE`, `stallM` output 1: hold the corresponding pipeline register.
- `flushD`, `flushE`, `flushW` output 1: load a bubble into the corresponding pipeline register.
- `mem_err` output 1: sticky memory-timeout flag.
- `stall_cnt`, `flush_cnt` output `CNT_W`: saturating event counters.

## Operation
- Memory FSM states are IDLE, WAIT and ERR; reset state is IDLE.
- IDLE:
  - `dmem_req & ~dmem_ack` goes to WAIT and clears the wait counter.
  - A request acknowledged in the same cycle stays in IDLE with no stall.
- WAIT:
  - `dmem_ack` returns to IDLE.
  - Otherwise the wait counter increments.
  - When the counter reaches `TIMEOUT-1` without ack, go to ERR.
  - `dmem_req` dropping while in WAIT also returns to IDLE, as an abandoned access.
- ERR: terminal until reset; `mem_err`=1.
- `mem_hold` is true in WAIT and ERR, and also in the IDLE cycle where `dmem_req & ~dmem_ack`. In that first cycle the hold is combinational from the inputs.
- `lw_use` = (`wb_selE`==2'b10) & `reg_wrE` & (`waddrE`!=0) & ((`waddrE`==`raddr1D`) | (`waddrE`==`raddr2D`)).
- Outputs are resolved in this priority order:
  1. `mem_hold`: `stallF`=`stallD`=`stallE`=`stallM`=1 and `flushW`=1. All other flushes are 0. Branch and load-use are ignored because E is frozen and they re-evaluate after release.
  2. `br_takenE`: `flushD`=`flushE`=1, all stalls 0. Any concurrent `lw_use` is ignored because the dependent instruction is squashed.
  3. `lw_use`: `stallF`=`stallD`=1, `flushE`=1.
  4. Otherwise all control outputs are 0.
- `stall_cnt` increments in every cycle where `stallF`=1.
- `flush_cnt` increments in every cycle where `flushD`=1, i.e. once per taken branch.
- Both counters saturate at all-ones and never wrap.

## Timing
- Reset (`rst`=0 at a clock edge) puts the FSM in IDLE and zeroes the wait counter, `mem_err`, `stall_cnt` and `flush_cnt`.
- While `rst`=0, all stall and flush outputs are 0.
- Reset asserted in WAIT or ERR aborts the wait; outputs are 0 from the next cycle.
- Stall/flush outputs are combinational from the inputs and FSM state, so they take effect at the same edge that would otherwise advance the pipe.
- Load-use costs exactly one bubble: the cycle after the stall, the load is in M and forwarding covers the dependency.
- Taken branch costs two bubbles (D and E).
- Memory wait costs N cycles of full freeze for an ack arriving N cycles after `dmem_req` rises.
- The ack cycle itself is not stalled: the pipe advances on the edge where `dmem_ack`=1.
- ERR is entered on the edge after the `TIMEOUT`-th consecutive unacked cycle in WAIT. The pipeline stays frozen from then on.
- `mem_err`, `stall_cnt` and `flush_cnt` are registered and update one edge after the event.

## Test plan
- Load-use on rs1: `wb_selE`=10, `reg_wrE`=1, `waddrE`=5, `raddr1D`=5 for one cycle. Required: `stallF`=`stallD`=`flushE`=1 for exactly that cycle; `stall_cnt` goes 0→1.
- x0 and non-load cases:
  - `waddrE`=0, `raddr2D`=0 with load select → no stall.
  - Same registers with `wb_selE`=01 → no stall.
- Branch beats load-use: `br_takenE`=1 together with the load-use condition. Required: `flushD`=`flushE`=1, `stallF`=0; `flush_cnt`=1, `stall_cnt`=0.
- Memory wait: `dmem_req`=1, ack held low 3 cycles and then high. Required:
  - all four stalls and `flushW` high for 3 cycles, low in the ack cycle;
  - FSM back in IDLE;
  - a branch asserted during the wait produces no flush until release.
- Timeout: `TIMEOUT`=4, `dmem_req`=1 and `dmem_ack`=0 forever. Required:
  - `mem_err` rises after the 4th unacked cycle in WAIT and stays high;
  - stalls stay high;
  - `rst`=0 for one edge clears everything.
- Counter saturation: `CNT_W`=2 with 5 load-use cycles → `stall_cnt` reads 3 and holds.
